// File: rtl/sun_pll_ctrl.sv
// rtl/sun_pll_ctrl.sv - SUN PLL power-up sequencer and lock supervisor
// Optional loss-of-lock flag (lol/lol_clr) enabled by SUN_PLL_CTRL_LOL_EN.
module sun_pll_ctrl #(
    parameter int BIAS_WAIT = 16,
    parameter int KICK_LEN  = 4,
    parameter int LOCK_CNT  = 64,
    parameter int LOSS_CNT  = 8,
    parameter int TIMEOUT   = 4096,
    parameter int MAX_RETRY = 3
) (
    input  logic       ck_ref,
    input  logic       reset_n,
    input  logic       en,
    input  logic       lock_raw,
    output logic       pwrup_bias,
    output logic       pwrup_1v8,
    output logic       kick,
    output logic       locked,
    output logic       fail,
    output logic [2:0] state
`ifdef SUN_PLL_CTRL_LOL_EN
    ,
    output logic       lol,
    input  logic       lol_clr
`endif
);

    localparam int ST_MAX = (BIAS_WAIT > KICK_LEN) ? BIAS_WAIT : KICK_LEN;
    localparam int ST_W   = $clog2(ST_MAX + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int LOSS_W = $clog2(LOSS_CNT + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_BIAS    = 3'd1,
        S_KICK    = 3'd2,
        S_ACQ     = 3'd3,
        S_RESTART = 3'd4,
        S_LOCK    = 3'd5,
        S_FAIL    = 3'd6
    } state_t;

    state_t            cur;
    state_t            nxt;
    logic              lk_m;
    logic              lk_s;
    logic [ST_W-1:0]   st_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic [LOSS_W-1:0] loss_cnt;
    logic [RTY_W-1:0]  retry;
    logic              lock_hit;
    logic              timeout_hit;
    logic              loss_hit;

    assign state = cur;

    always_ff @(posedge ck_ref or negedge reset_n) begin
        if (!reset_n) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= lock_raw;
            lk_s <= lk_m;
        end
    end

    always_comb begin
        lock_hit    = lk_s && (run_cnt == RUN_W'(LOCK_CNT - 1));
        timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));
        loss_hit    = !lk_s && (loss_cnt == LOSS_W'(LOSS_CNT - 1));
        nxt         = cur;
        case (cur)
            S_OFF:     if (en) nxt = S_BIAS;
            S_BIAS:    if (st_cnt == ST_W'(BIAS_WAIT - 1)) nxt = S_KICK;
            S_KICK:    if (st_cnt == ST_W'(KICK_LEN - 1)) nxt = S_ACQ;
            S_ACQ: begin
                // A lock qualifying on the timeout cycle takes priority.
                if (lock_hit)
                    nxt = S_LOCK;
                else if (timeout_hit)
                    nxt = (retry < RTY_W'(MAX_RETRY)) ? S_RESTART : S_FAIL;
            end
            S_RESTART: if (st_cnt == ST_W'(KICK_LEN - 1)) nxt = S_KICK;
            S_LOCK:    if (loss_hit) nxt = S_ACQ;
            S_FAIL:    nxt = S_FAIL;
            default:   nxt = S_OFF;
        endcase
        if (!en) nxt = S_OFF;
    end

    always_ff @(posedge ck_ref or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= S_OFF;
            st_cnt   <= '0;
            to_cnt   <= '0;
            run_cnt  <= '0;
            loss_cnt <= '0;
            retry    <= '0;
        end else begin
            cur <= nxt;

            if (!en || nxt != cur)
                st_cnt <= '0;
            else if (st_cnt != ST_W'(ST_MAX))
                st_cnt <= st_cnt + 1'b1;

            if (!en || cur != S_ACQ || nxt != S_ACQ)
                to_cnt <= '0;
            else if (to_cnt != TO_W'(TIMEOUT))
                to_cnt <= to_cnt + 1'b1;

            if (!en || cur != S_ACQ || !lk_s)
                run_cnt <= '0;
            else if (run_cnt != RUN_W'(LOCK_CNT))
                run_cnt <= run_cnt + 1'b1;

            if (!en || cur != S_LOCK || lk_s)
                loss_cnt <= '0;
            else if (loss_cnt != LOSS_W'(LOSS_CNT))
                loss_cnt <= loss_cnt + 1'b1;

            // A fresh acquisition after a loss of lock gets a full retry budget.
            if (!en || (cur == S_LOCK && nxt == S_ACQ))
                retry <= '0;
            else if (cur == S_ACQ && nxt == S_RESTART)
                retry <= retry + 1'b1;
        end
    end

    // Outputs are flopped from the next state so they line up with the state register.
    always_ff @(posedge ck_ref or negedge reset_n) begin
        if (!reset_n) begin
            pwrup_bias <= 1'b0;
            pwrup_1v8  <= 1'b0;
            kick       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            pwrup_bias <= (nxt == S_BIAS) || (nxt == S_KICK) || (nxt == S_ACQ) ||
                          (nxt == S_RESTART) || (nxt == S_LOCK);
            pwrup_1v8  <= (nxt == S_KICK) || (nxt == S_ACQ) || (nxt == S_LOCK);
            kick       <= (nxt == S_KICK);
            locked     <= (nxt == S_LOCK);
            fail       <= (nxt == S_FAIL);
        end
    end

`ifdef SUN_PLL_CTRL_LOL_EN
    always_ff @(posedge ck_ref or negedge reset_n) begin
        if (!reset_n)
            lol <= 1'b0;
        else if (cur == S_LOCK && nxt == S_ACQ)
            lol <= 1'b1;
        else if (lol_clr)
            lol <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_sun_pll_ctrl.sv
// tb/tb_sun_pll_ctrl.sv - directed self-checking bench for sun_pll_ctrl
module tb_sun_pll_ctrl;

    logic       ck_ref = 1'b0;
    logic       reset_n;
    logic       en;
    logic       lock_raw;
    logic       pwrup_bias;
    logic       pwrup_1v8;
    logic       kick;
    logic       locked;
    logic       fail;
    logic [2:0] state;
`ifdef SUN_PLL_CTRL_LOL_EN
    logic       lol;
    logic       lol_clr;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int rst_cycles = 0;
    int lock_seen = 0;

    // {state, pwrup_bias, pwrup_1v8, kick, locked, fail}
    localparam logic [31:0] O_OFF  = 32'b000_00000;
    localparam logic [31:0] O_BIAS = 32'b001_10000;
    localparam logic [31:0] O_KICK = 32'b010_11100;
    localparam logic [31:0] O_ACQ  = 32'b011_11000;
    localparam logic [31:0] O_RST  = 32'b100_10000;
    localparam logic [31:0] O_LOCK = 32'b101_11010;
    localparam logic [31:0] O_FAIL = 32'b110_00001;

    sun_pll_ctrl dut (
        .ck_ref     (ck_ref),
        .reset_n    (reset_n),
        .en         (en),
        .lock_raw   (lock_raw),
        .pwrup_bias (pwrup_bias),
        .pwrup_1v8  (pwrup_1v8),
        .kick       (kick),
        .locked     (locked),
        .fail       (fail),
        .state      (state)
`ifdef SUN_PLL_CTRL_LOL_EN
        ,
        .lol        (lol),
        .lol_clr    (lol_clr)
`endif
    );

    always #5 ck_ref = ~ck_ref;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] obs();
        return {24'd0, state, pwrup_bias, pwrup_1v8, kick, locked, fail};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ck_ref);
            #1;
            if (state == 3'd4 && pwrup_bias && !pwrup_1v8) rst_cycles++;
            if (locked) lock_seen++;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b0;
        lock_raw = 1'b1;
`ifdef SUN_PLL_CTRL_LOL_EN
        lol_clr  = 1'b0;
`endif
        tick(3);
        check("reset_state", obs(), O_OFF);
        reset_n = 1'b1;
        tick(2);
        check("idle_off", obs(), O_OFF);

        // Power-up with lock present: edges counted from en rising.
        en = 1'b1;
        tick(1);  check("t1_bias_c1", obs(), O_BIAS);
        tick(15); check("t1_bias_c16", obs(), O_BIAS);
        tick(1);  check("t1_kick_c17", obs(), O_KICK);
        tick(3);  check("t1_kick_c20", obs(), O_KICK);
        tick(1);  check("t1_acq_c21", obs(), O_ACQ);
        tick(63); check("t1_acq_c84", obs(), O_ACQ);
        tick(1);  check("t1_lock_c85", obs(), O_LOCK);

        // Short dropout of 7 cycles is tolerated.
        lock_raw = 1'b0; tick(7); lock_raw = 1'b1;
        tick(10); check("t3_drop7_locked", obs(), O_LOCK);

        // 8-cycle dropout loses lock after 2 sync cycles + 8 samples.
        lock_raw = 1'b0; tick(8); lock_raw = 1'b1;
        tick(1);  check("t3_drop8_still_lock", obs(), O_LOCK);
        tick(1);  check("t3_drop8_acq", obs(), O_ACQ);
        tick(63); check("t3_relock_pending", obs(), O_ACQ);
        tick(1);  check("t3_relock", obs(), O_LOCK);

        // en low in LOCK, then in KICK.
        en = 1'b0; tick(1); check("t5_en_off_lock", obs(), O_OFF);
        en = 1'b1; tick(18); check("t5_in_kick", obs(), O_KICK);
        en = 1'b0; tick(1);  check("t5_en_off_kick", obs(), O_OFF);

        // No lock: attempt period is 8 + 4096 cycles, FAIL after 4th timeout.
        lock_raw = 1'b0; tick(2);
        rst_cycles = 0; lock_seen = 0;
        en = 1'b1;
        tick(4116); check("t2_acq_before_to", obs(), O_ACQ);
        tick(1);    check("t2_restart1", obs(), O_RST);
        tick(4);    check("t2_kick_again", obs(), O_KICK);
        tick(4);    check("t2_acq_again", obs(), O_ACQ);
        tick(12303); check("t2_acq_last", obs(), O_ACQ);
        tick(1);    check("t2_fail", obs(), O_FAIL);
        check("t2_restart_cycles", rst_cycles, 32'd12);
        tick(20);   check("t2_fail_sticky", obs(), O_FAIL);
        en = 1'b0; tick(1); check("t2_fail_cleared", obs(), O_OFF);
        check("t2_no_lock", lock_seen, 32'd0);

        // Toggling lock every 10 cycles never qualifies.
        lock_raw = 1'b1; lock_seen = 0;
        en = 1'b1;
        for (int i = 0; i < 4117; i++) begin
            if (i % 10 == 0) lock_raw = ~lock_raw;
            tick(1);
        end
        check("t4_restart", obs(), O_RST);
        check("t4_no_lock", lock_seen, 32'd0);
        en = 1'b0; tick(1);

        // Asynchronous reset mid-ACQ.
        lock_raw = 1'b0; en = 1'b1;
        tick(30); check("t5_acq", obs(), O_ACQ);
        #2; reset_n = 1'b0; #1;
        check("t5_async_reset", obs(), O_OFF);
        tick(2); check("t5_reset_hold", obs(), O_OFF);
        en = 1'b0; lock_raw = 1'b1;
        reset_n = 1'b1;
        tick(2);

`ifdef SUN_PLL_CTRL_LOL_EN
        check("t6_lol_reset", {31'd0, lol}, 32'd0);
        en = 1'b1;
        tick(85); check("t6_lock", obs(), O_LOCK);
        check("t6_lol_clear_in_lock", {31'd0, lol}, 32'd0);
        lock_raw = 1'b0; tick(8); lock_raw = 1'b1;
        tick(2); check("t6_loss_acq", obs(), O_ACQ);
        check("t6_lol_set", {31'd0, lol}, 32'd1);
        tick(64); check("t6_relock", obs(), O_LOCK);
        check("t6_lol_kept", {31'd0, lol}, 32'd1);
        lol_clr = 1'b1; tick(1); lol_clr = 1'b0;
        check("t6_lol_cleared", {31'd0, lol}, 32'd0);
        lol_clr = 1'b1;
        lock_raw = 1'b0; tick(8); lock_raw = 1'b1;
        tick(2); check("t6_loss2_acq", obs(), O_ACQ);
        check("t6_set_wins", {31'd0, lol}, 32'd1);
        lol_clr = 1'b0;
        tick(1); check("t6_lol_hold", {31'd0, lol}, 32'd1);
        en = 1'b0; tick(1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
